// File: rtl/wb_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter_if
//
// Bundles every Wishbone signal around the RAM arbiter: the packed per-master
// request fields (master k occupies slice [k*W +: W]), the per-master return
// path, and the single shared slave port toward the RAM.
//
// Modports
//   slave  : the arbiter's view. It is the Wishbone slave of all masters and
//            drives the shared port toward the RAM.
//   master : the surrounding system's view. It drives the master requests and
//            the RAM responses, and observes everything the arbiter drives.
//
// Parameters
//   num_masters : number of requesting masters
//   dw          : data width
//   aw          : address width
// ---------------------------------------------------------------------------
interface wb_ram_arbiter_if #(
    parameter int num_masters = 2,
    parameter int dw          = 32,
    parameter int aw          = 32
);
    // Master request side
    logic [num_masters*aw-1:0] m_adr_i;
    logic [num_masters*dw-1:0] m_dat_i;
    logic [num_masters*4-1:0]  m_sel_i;
    logic [num_masters-1:0]    m_we_i;
    logic [num_masters*3-1:0]  m_cti_i;
    logic [num_masters*2-1:0]  m_bte_i;
    logic [num_masters-1:0]    m_cyc_i;
    logic [num_masters-1:0]    m_stb_i;
    // Master return side
    logic [num_masters*dw-1:0] m_dat_o;
    logic [num_masters-1:0]    m_ack_o;
    logic [num_masters-1:0]    m_err_o;
    // Shared slave port
    logic [aw-1:0]             s_adr_o;
    logic [dw-1:0]             s_dat_o;
    logic [3:0]                s_sel_o;
    logic                      s_we_o;
    logic [2:0]                s_cti_o;
    logic [1:0]                s_bte_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic [dw-1:0]             s_dat_i;
    logic                      s_ack_i;
    logic                      s_err_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
//
// Round-robin Wishbone B3 arbiter sharing one wb_ram slave port between
// num_masters masters. A master keeps the grant for as long as it holds cyc,
// so bursts reach the RAM unbroken. The shared port is an AND-OR mux driven by
// the registered one-hot grant; ack, err and read data go back to the owner
// only.
//
// Ports
//   wb_clk_i  : clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : Wishbone signals (master requests/returns, shared slave port)
//   grant_o   : registered one-hot grant, all-zero when idle
// ---------------------------------------------------------------------------
module wb_ram_arbiter #(
    parameter int num_masters = 2,
    parameter int dw          = 32,
    parameter int aw          = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_ram_arbiter_if.slave        bus,
    output logic [num_masters-1:0] grant_o
);
    localparam int lw = (num_masters > 1) ? $clog2(num_masters) : 1;

    logic [num_masters-1:0] grant_q, grant_d;
    logic [lw-1:0]          last_q, last_d;
    logic                   owner_cyc;
    logic                   found;
    int                     idx;
    logic [lw-1:0]          idx_l;

    // Arbitration: re-decide only when the bus is free (idle, or the owner has
    // dropped cyc). The scan starts just after the previous owner, so the
    // previous owner has the lowest priority. Handover needs no idle cycle.
    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        found     = 1'b0;
        idx       = 0;
        idx_l     = '0;
        owner_cyc = |(grant_q & bus.m_cyc_i);
        if (!owner_cyc) begin
            grant_d = '0;
            for (int i = 1; i <= num_masters; i++) begin
                idx = int'(last_q) + i;
                if (idx >= num_masters) begin
                    idx = idx - num_masters;
                end
                idx_l = lw'(idx);
                if (!found && bus.m_cyc_i[idx_l]) begin
                    grant_d[idx_l] = 1'b1;
                    last_d         = idx_l;
                    found          = 1'b1;
                end
            end
        end
    end

    // last resets to the highest index so master 0 wins the first decision.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            grant_q <= '0;
            last_q  <= lw'(num_masters - 1);
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;

    // Cycle/strobe follow the owner's live signals, so the cycle in which the
    // owner drops cyc already shows s_cyc_o=0 to the RAM.
    assign bus.s_cyc_o = |(grant_q & bus.m_cyc_i);
    assign bus.s_stb_o = |(grant_q & bus.m_stb_i);
    assign bus.m_ack_o = grant_q & {num_masters{bus.s_ack_i}};
    assign bus.m_err_o = grant_q & {num_masters{bus.s_err_i}};

    // AND-OR mux of the owner's fields; every field reads 0 with no owner.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        bus.m_dat_o = '0;
        for (int k = 0; k < num_masters; k++) begin
            bus.s_adr_o = bus.s_adr_o | ({aw{grant_q[k]}} & bus.m_adr_i[k*aw +: aw]);
            bus.s_dat_o = bus.s_dat_o | ({dw{grant_q[k]}} & bus.m_dat_i[k*dw +: dw]);
            bus.s_sel_o = bus.s_sel_o | ({4{grant_q[k]}} & bus.m_sel_i[k*4 +: 4]);
            bus.s_we_o  = bus.s_we_o | (grant_q[k] & bus.m_we_i[k]);
            bus.s_cti_o = bus.s_cti_o | ({3{grant_q[k]}} & bus.m_cti_i[k*3 +: 3]);
            bus.s_bte_o = bus.s_bte_o | ({2{grant_q[k]}} & bus.m_bte_i[k*2 +: 2]);
            bus.m_dat_o[k*dw +: dw] = grant_q[k] ? bus.s_dat_i : '0;
        end
    end
endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Round-robin Wishbone B3 arbiter that shares one wb_ram slave port between num_masters masters (e.g. CPU instruction bus, CPU data bus, debug/DMA).
- Grant is held for a master's whole cycle (cyc high), so incrementing and wrap bursts reach the RAM unbroken.
- Slave address, data and control are muxed from the owner; ack, err and read data are routed back only to the owner.
- Sits between the masters' bus ports and the RAM instance.

Parameters:
num_masters, 2, number of requesting masters (2..8)
dw, 32, data width
aw, 32, address width passed through to the slave

Ports:
wb_clk_i  input  1  clock
wb_rst_ni  input  1  asynchronous active-low reset
m_adr_i  input  num_masters*aw  master addresses, master k at [k*aw +: aw]
m_dat_i  input  num_masters*dw  master write data
m_sel_i  input  num_masters*4  master byte selects
m_we_i  input  num_masters  master write enables
m_cti_i  input  num_masters*3  master cycle type identifiers
m_bte_i  input  num_masters*2  master burst type extensions
m_cyc_i  input  num_masters  master cycle requests
m_stb_i  input  num_masters  master strobes
m_dat_o  output  num_masters*dw  read data; slave data to the owner, zero to all others
m_ack_o  output  num_masters  per-master ack
m_err_o  output  num_masters  per-master err
s_adr_o  output  aw  slave address
s_dat_o  output  dw  slave write data
s_sel_o  output  4  slave byte selects
s_we_o  output  1  slave write enable
s_cti_o  output  3  slave cycle type identifier
s_bte_o  output  2  slave burst type extension
s_cyc_o  output  1  slave cycle
s_stb_o  output  1  slave strobe
s_dat_i  input  dw  slave read data
s_ack_i  input  1  slave ack
s_err_i  input  1  slave err
grant_o  output  num_masters  registered one-hot grant, all-zero when idle

Behaviour:
- State:
  - grant: registered, one-hot or zero.
  - last: index of the most recent owner.
  - The arbiter is IDLE when grant==0 and OWNED otherwise.
- Reset (wb_rst_ni low, asynchronous):
  - grant=0, last=num_masters-1, so master 0 has highest priority first.
  - All outputs are then 0: s_cyc_o, s_stb_o, m_ack_o, m_err_o and grant_o all 0; s_* data/address are muxed from no owner and read as 0.
- Arbitration decision, evaluated every clock when no master holds the bus:
  - "Free" means IDLE, or OWNED with the owner's m_cyc_i low.
  - The winner is the first requester with m_cyc_i high, scanning last+1, last+2, ... modulo num_masters.
  - At the clock edge: grant <= onehot(winner), last <= winner.
  - If no requester, grant <= 0.
- Hold: while OWNED and the owner's m_cyc_i is high, grant is unchanged.
  - This holds regardless of m_stb_i, cti or requests from other masters.
  - No preemption and no timeout.
- Latency:
  - A request from IDLE is granted on the edge after m_cyc_i rises. The slave sees cyc/stb one cycle after the master raises them.
  - Handover needs zero idle cycles. In the cycle the owner drops cyc, the next winner is selected, and its grant takes effect on that edge.
- Slave muxing, combinational from the registered grant:
  - s_cyc_o = |(grant & m_cyc_i); s_stb_o = |(grant & m_stb_i).
  - s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o and s_bte_o are an AND-OR mux of the owner's fields, 0 when IDLE.
- Return path:
  - m_ack_o[k] = grant[k] & s_ack_i; m_err_o[k] = grant[k] & s_err_i.
  - m_dat_o slice k = grant[k] ? s_dat_i : 0.
  - Non-owners never see ack or err.
- Stale ack safety:
  - The cycle in which the owner drops cyc drives s_cyc_o=0. A registered-ack slave therefore returns no ack on the new owner's first cycle.
  - The arbiter adds no extra gating; the bench checks this property.
- A master dropping stb but keeping cyc (wait states inside a burst) keeps the grant.
- Reset asserted mid-burst:
  - grant clears immediately (asynchronous), so s_cyc_o, s_stb_o and all acks fall in the same cycle.
  - After release, arbitration restarts with master 0 first.
- num_masters=1 degenerates to a registered pass-through with one cycle of grant latency.

Test Plan:
- Reset, then master 0 asserts cyc/stb, classic read adr=0x10 -> grant_o=01 after 1 edge, s_adr_o=0x10, ack only on m_ack_o[0], m_dat_o[1]=0.
- Masters 0 and 1 raise cyc on the same cycle, each doing one classic write -> master 0 served first; grant_o goes 01 -> 10 on the edge after master 0 drops cyc, with no idle cycle; RAM contents match both writes.
- Both masters request continuously with repeated single cycles -> grants alternate 0,1,0,1 over 8 cycles; neither gets two consecutive grants while the other waits.
- Master 1 runs a 4-beat incrementing burst (cti=010, bte=00, adr=0x20) while master 0 requests mid-burst -> grant stays 10 through the cti=111 beat; 4 acks reach master 1 with data 0x20..0x2C; master 0 is granted only after master 1 drops cyc.
- Owner drops stb for 3 cycles mid-burst while keeping cyc, and the other master requests -> grant unchanged, no ack during the gap, burst completes.
- wb_rst_ni pulled low for one cycle mid-burst -> s_cyc_o and grant_o are 0 in the same cycle; after release with both requesting, master 0 is granted first.
